// File: rtl/csa_resolve_adder.sv
// Two-stage pipelined resolver for the carry/sum pair produced by a 4:2 compressor.
// Stage 1 adds the low LO_WIDTH bits and registers the carry-out together with the
// untouched upper halves. Stage 2 adds the upper halves plus that carry. Both stages
// use a valid/ready handshake, so the pipeline holds up to two entries and sustains
// one result per cycle while the consumer keeps out_ready high.
module csa_resolve_adder #(
  parameter int unsigned OP_WIDTH = 32,
  // Legal range is 1..OP_WIDTH, which keeps the upper slice at least one bit wide.
  parameter int unsigned LO_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [OP_WIDTH:0]     in_c,
  input  logic [OP_WIDTH:0]     in_s,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [OP_WIDTH+1:0]   out_sum,
  output logic                  busy
);

  localparam int unsigned HiWidth = OP_WIDTH + 1 - LO_WIDTH;

  // Stage 1 state
  logic                s1_valid_q, s1_valid_d;
  logic [LO_WIDTH-1:0] s1_lo_q, s1_lo_d;
  logic                s1_cy_q, s1_cy_d;
  logic [HiWidth-1:0]  s1_c_hi_q, s1_c_hi_d;
  logic [HiWidth-1:0]  s1_s_hi_q, s1_s_hi_d;

  // Stage 2 state
  logic                s2_valid_q, s2_valid_d;
  logic [OP_WIDTH+1:0] s2_sum_q, s2_sum_d;

  // Handshake terms
  logic s2_free;
  logic s1_adv;
  logic in_fire;

  // Datapath intermediates
  logic [LO_WIDTH:0]   lo_add;
  logic [HiWidth:0]    hi_add;

  // Flow control: stage 2 frees up when empty or draining; stage 1 moves into it.
  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    in_fire  = in_valid && in_ready;
  end

  // Low-half add; the extra MSB is the carry handed to stage 2.
  always_comb begin
    lo_add = {1'b0, in_c[LO_WIDTH-1:0]} + {1'b0, in_s[LO_WIDTH-1:0]};
  end

  // High-half add, one bit wider than the slices so the final carry-out is kept.
  always_comb begin
    hi_add = {1'b0, s1_c_hi_q} + {1'b0, s1_s_hi_q} + {{HiWidth{1'b0}}, s1_cy_q};
  end

  // Stage 1 next state: load on accept, empty when it advances without a refill.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_lo_d    = s1_lo_q;
    s1_cy_d    = s1_cy_q;
    s1_c_hi_d  = s1_c_hi_q;
    s1_s_hi_d  = s1_s_hi_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_lo_d    = lo_add[LO_WIDTH-1:0];
      s1_cy_d    = lo_add[LO_WIDTH];
      s1_c_hi_d  = in_c[OP_WIDTH:LO_WIDTH];
      s1_s_hi_d  = in_s[OP_WIDTH:LO_WIDTH];
    end else if (s1_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // Stage 2 next state: load when stage 1 advances, empty on a drain without refill.
  always_comb begin
    s2_valid_d = s2_valid_q;
    s2_sum_d   = s2_sum_q;
    if (s1_adv) begin
      s2_valid_d = 1'b1;
      s2_sum_d   = {hi_add, s1_lo_q};
    end else if (out_ready) begin
      s2_valid_d = 1'b0;
    end
  end

  // Stage 1 registers; data only changes on its load enable.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_lo_q    <= '0;
      s1_cy_q    <= 1'b0;
      s1_c_hi_q  <= '0;
      s1_s_hi_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_lo_q    <= s1_lo_d;
      s1_cy_q    <= s1_cy_d;
      s1_c_hi_q  <= s1_c_hi_d;
      s1_s_hi_q  <= s1_s_hi_d;
    end
  end

  // Stage 2 registers drive the outputs directly.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      s2_valid_q <= 1'b0;
      s2_sum_q   <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      s2_sum_q   <= s2_sum_d;
    end
  end

  // Registered outputs plus occupancy flag.
  always_comb begin
    out_valid = s2_valid_q;
    out_sum   = s2_sum_q;
    busy      = s1_valid_q || s2_valid_q;
  end

endmodule

// File: tb/tb_csa_resolve_adder.sv
// Self-checking bench for csa_resolve_adder (OP_WIDTH=32, LO_WIDTH=16).
module tb_csa_resolve_adder;

  localparam int unsigned OpW = 32;
  localparam int unsigned LoW = 16;

  logic           clock;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [OpW:0]   in_c;
  logic [OpW:0]   in_s;
  logic           out_valid;
  logic           out_ready;
  logic [OpW+1:0] out_sum;
  logic           busy;

  int checks;
  int errors;

  logic [OpW+1:0] exp_q[$];

  typedef struct {
    string          name;
    logic [OpW:0]   c;
    logic [OpW:0]   s;
    logic [OpW+1:0] sum;
  } vec_t;

  vec_t vecs[9];

  csa_resolve_adder #(
    .OP_WIDTH(OpW),
    .LO_WIDTH(LoW)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_c     (in_c),
    .in_s     (in_s),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .busy     (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  function automatic logic [OpW:0] rand_op();
    logic [OpW:0] v;
    v = {1'($urandom_range(1, 0)), 32'($urandom())};
    return v;
  endfunction

  // One clock: sample handshakes before the edge, update the scoreboard, then
  // advance to just after the edge. check_busy compares busy with in-flight count.
  task automatic step(input bit check_busy, output bit fired);
    #1;
    fired = 1'b0;
    if (check_busy) check("busy_vs_inflight", 64'(busy), 64'(exp_q.size() != 0));
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'(out_valid), 64'(0));
      end else begin
        check("scoreboard_sum", 64'(out_sum), 64'(exp_q.pop_front()));
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back({1'b0, in_c} + {1'b0, in_s});
      fired = 1'b1;
    end
    @(posedge clock);
    #1;
  endtask

  initial begin
    bit fired;
    int acc;
    int bad;
    int done;
    int cyc;
    logic [OpW+1:0] held;

    vecs[0] = '{"split_carry", 33'h0_0000_FFFE, 33'h0_0000_0003, 34'h0_0001_0001};
    vecs[1] = '{"max_operands", 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 34'h3_FFFF_FFFE};
    vecs[2] = '{"zeros", 33'h0_0000_0000, 33'h0_0000_0000, 34'h0_0000_0000};
    vecs[3] = '{"lo_all_ones", 33'h0_0000_FFFF, 33'h0_0000_0001, 34'h0_0001_0000};
    vecs[4] = '{"msb_carry", 33'h1_0000_0000, 33'h1_0000_0000, 34'h2_0000_0000};
    vecs[5] = '{"full_ripple", 33'h0_FFFF_FFFF, 33'h0_0000_0001, 34'h1_0000_0000};
    vecs[6] = '{"mixed", 33'h1_2345_6789, 33'h0_1111_1111, 34'h1_3456_789A};
    vecs[7] = '{"ripple_to_top", 33'h1_FFFF_FFFF, 33'h0_0000_0001, 34'h2_0000_0000};
    vecs[8] = '{"both_halves", 33'h0_8000_8000, 33'h0_8000_8000, 34'h1_0001_0000};

    checks = 0;
    errors = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_c = '0;
    in_s = '0;
    out_ready = 1'b1;
    #2;
    check("reset_out_valid", 64'(out_valid), 64'(0));
    check("reset_out_sum", 64'(out_sum), 64'(0));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Directed vectors, one at a time, checking the two-cycle latency.
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_c = vecs[i].c;
      in_s = vecs[i].s;
      out_ready = 1'b1;
      step(1'b1, fired);
      check({vecs[i].name, "_accept"}, 64'(fired), 64'(1));
      in_valid = 1'b0;
      step(1'b1, fired);
      check({vecs[i].name, "_valid"}, 64'(out_valid), 64'(1));
      check({vecs[i].name, "_sum"}, 64'(out_sum), 64'(vecs[i].sum));
      step(1'b1, fired);
    end

    // Streaming: 64 back-to-back pairs, one result per cycle after fill.
    bad = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 66; i++) begin
      in_valid = (i < 64);
      in_c = rand_op();
      in_s = rand_op();
      step(1'b1, fired);
      if (i < 64 && !fired) bad++;
      if (out_valid !== ((i >= 1) && (i <= 64))) bad++;
    end
    in_valid = 1'b0;
    check("stream_cadence_errors", 64'(bad), 64'(0));
    check("stream_drained", 64'(exp_q.size()), 64'(0));

    // Backpressure: five stalled cycles accept exactly two pairs.
    acc = 0;
    held = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_c = rand_op();
      in_s = rand_op();
      step(1'b1, fired);
      if (fired) acc++;
      if (i == 1) held = out_sum;
    end
    #1;
    check("bp_accepted", 64'(acc), 64'(2));
    check("bp_in_ready", 64'(in_ready), 64'(0));
    check("bp_out_valid", 64'(out_valid), 64'(1));
    check("bp_sum_stable", 64'(out_sum), 64'(held));
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc = 0;
    while ((exp_q.size() != 0 || busy) && cyc < 10) begin
      step(1'b1, fired);
      cyc++;
    end
    check("bp_drain_empty", 64'(exp_q.size()), 64'(0));
    check("bp_drain_idle", 64'(busy), 64'(0));

    // Reset with both stages full discards the in-flight pairs.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_c = 33'h1_FFFF_FFFF;
      in_s = 33'h0_0000_0001;
      step(1'b1, fired);
    end
    in_valid = 1'b0;
    #1;
    check("pre_reset_full", 64'({busy, in_ready}), 64'(2'b10));
    reset = 1'b1;
    #1;
    check("midreset_out_valid", 64'(out_valid), 64'(0));
    check("midreset_busy", 64'(busy), 64'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("post_reset_in_ready", 64'(in_ready), 64'(1));
    check("post_reset_out_sum", 64'(out_sum), 64'(0));
    @(posedge clock);
    #1;
    out_ready = 1'b1;
    check("post_reset_no_output", 64'(out_valid), 64'(0));

    // Random valid/ready toggling until 1000 results have been checked.
    done = 0;
    cyc = 0;
    while (done < 1000 && cyc < 20000) begin
      in_valid = ($urandom_range(3, 0) != 0);
      out_ready = ($urandom_range(2, 0) != 0);
      in_c = rand_op();
      in_s = rand_op();
      #1;
      if (out_valid && out_ready) done++;
      step(1'b1, fired);
      cyc++;
    end
    check("random_completed", 64'(done), 64'(1000));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
